// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-FU result FIFOs drained round-robin onto two ROB writeback ports.
// Latency: 1 cycle minimum from FU push to registered wb_* output; no bypass.
// Backpressure: fu_ready[i] drops while FU i's FIFO is full; the writeback side never stalls.
module wb_arbiter #(
  parameter int FU_NUMBER      = 4,
  parameter int R_ADDR         = 6,
  parameter int ROB_INDEX_BITS = 3,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [FU_NUMBER-1:0]          fu_valid,
  input  logic [FU_NUMBER*R_ADDR-1:0]   fu_dest,
  input  logic [FU_NUMBER*32-1:0]       fu_data,
  input  logic [FU_NUMBER*ROB_INDEX_BITS-1:0] fu_ticket,
  input  logic [FU_NUMBER-1:0]          fu_exc_valid,
  input  logic [FU_NUMBER*4-1:0]        fu_exc_cause,
  output logic [FU_NUMBER-1:0]          fu_ready,
  output logic [1:0]                    wb_valid,
  output logic [2*R_ADDR-1:0]           wb_dest,
  output logic [63:0]                   wb_data,
  output logic [2*ROB_INDEX_BITS-1:0]   wb_ticket,
  output logic [1:0]                    wb_exc_valid,
  output logic [7:0]                    wb_exc_cause,
  output logic [3:0]                    wb_src_fu
);
  localparam int FW = (FU_NUMBER > 1) ? $clog2(FU_NUMBER) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [R_ADDR-1:0]         dest;
    logic [31:0]               data;
    logic [ROB_INDEX_BITS-1:0] ticket;
    logic                      exc_valid;
    logic [3:0]                exc_cause;
  } entry_t;

  entry_t          mem      [FU_NUMBER][FIFO_DEPTH];
  entry_t          fu_entry [FU_NUMBER];
  logic [PW-1:0]   rd_ptr   [FU_NUMBER];
  logic [PW-1:0]   wr_ptr   [FU_NUMBER];
  logic [CW-1:0]   count    [FU_NUMBER];
  logic            ready_en;
  logic [FW-1:0]   rr_ptr;
  logic [FU_NUMBER-1:0] push;
  logic [FU_NUMBER-1:0] pop;
  logic            g0_vld, g1_vld;
  logic [FW-1:0]   g0_idx, g1_idx;
  logic [FW:0]     scan_sum;
  logic [FW-1:0]   scan_idx;
  entry_t          head0, head1;
  logic [1:0]                  wb_valid_n;
  logic [2*R_ADDR-1:0]         wb_dest_n;
  logic [63:0]                 wb_data_n;
  logic [2*ROB_INDEX_BITS-1:0] wb_ticket_n;
  logic [1:0]                  wb_exc_valid_n;
  logic [7:0]                  wb_exc_cause_n;
  logic [3:0]                  wb_src_fu_n;

  function automatic logic [FW-1:0] next_fu(input logic [FW-1:0] f);
    return (f == FW'(FU_NUMBER - 1)) ? '0 : f + FW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < FU_NUMBER; i++) begin
      fu_entry[i].dest      = fu_dest[i*R_ADDR +: R_ADDR];
      fu_entry[i].data      = fu_data[i*32 +: 32];
      fu_entry[i].ticket    = fu_ticket[i*ROB_INDEX_BITS +: ROB_INDEX_BITS];
      fu_entry[i].exc_valid = fu_exc_valid[i];
      fu_entry[i].exc_cause = fu_exc_cause[i*4 +: 4];
      fu_ready[i]           = ready_en && (count[i] < CW'(FIFO_DEPTH));
    end
  end

  assign push = fu_valid & fu_ready & {FU_NUMBER{~flush}};

  // Round-robin scan from rr_ptr: first two non-empty heads win port 0 then port 1.
  always_comb begin
    g0_vld   = 1'b0;
    g1_vld   = 1'b0;
    g0_idx   = '0;
    g1_idx   = '0;
    pop      = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < FU_NUMBER; k++) begin
      scan_sum = {1'b0, rr_ptr} + (FW+1)'(k);
      if (scan_sum >= (FW+1)'(FU_NUMBER)) scan_sum = scan_sum - (FW+1)'(FU_NUMBER);
      scan_idx = scan_sum[FW-1:0];
      if (count[scan_idx] != '0) begin
        if (!g0_vld) begin
          g0_vld        = 1'b1;
          g0_idx        = scan_idx;
          pop[scan_idx] = ~flush;
        end else if (!g1_vld) begin
          g1_vld        = 1'b1;
          g1_idx        = scan_idx;
          pop[scan_idx] = ~flush;
        end
      end
    end
  end

  assign head0 = mem[g0_idx][rd_ptr[g0_idx]];
  assign head1 = mem[g1_idx][rd_ptr[g1_idx]];

  always_comb begin
    wb_valid_n     = '0;
    wb_dest_n      = '0;
    wb_data_n      = '0;
    wb_ticket_n    = '0;
    wb_exc_valid_n = '0;
    wb_exc_cause_n = '0;
    wb_src_fu_n    = '0;
    if (!flush && g0_vld) begin
      wb_valid_n[0]                    = 1'b1;
      wb_dest_n[R_ADDR-1:0]            = head0.dest;
      wb_data_n[31:0]                  = head0.data;
      wb_ticket_n[ROB_INDEX_BITS-1:0]  = head0.ticket;
      wb_exc_valid_n[0]                = head0.exc_valid;
      wb_exc_cause_n[3:0]              = head0.exc_cause;
      wb_src_fu_n[1:0]                 = 2'(g0_idx);
    end
    if (!flush && g1_vld) begin
      wb_valid_n[1]                                 = 1'b1;
      wb_dest_n[R_ADDR +: R_ADDR]                   = head1.dest;
      wb_data_n[63:32]                              = head1.data;
      wb_ticket_n[ROB_INDEX_BITS +: ROB_INDEX_BITS] = head1.ticket;
      wb_exc_valid_n[1]                             = head1.exc_valid;
      wb_exc_cause_n[7:4]                           = head1.exc_cause;
      wb_src_fu_n[3:2]                              = 2'(g1_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en     <= 1'b0;
      rr_ptr       <= '0;
      wb_valid     <= '0;
      wb_dest      <= '0;
      wb_data      <= '0;
      wb_ticket    <= '0;
      wb_exc_valid <= '0;
      wb_exc_cause <= '0;
      wb_src_fu    <= '0;
      for (int i = 0; i < FU_NUMBER; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
    end else begin
      ready_en     <= 1'b1;
      wb_valid     <= wb_valid_n;
      wb_dest      <= wb_dest_n;
      wb_data      <= wb_data_n;
      wb_ticket    <= wb_ticket_n;
      wb_exc_valid <= wb_exc_valid_n;
      wb_exc_cause <= wb_exc_cause_n;
      wb_src_fu    <= wb_src_fu_n;
      if (flush) begin
        // rr_ptr deliberately keeps its position across a flush.
        for (int i = 0; i < FU_NUMBER; i++) begin
          count[i]  <= '0;
          rd_ptr[i] <= '0;
          wr_ptr[i] <= '0;
        end
      end else begin
        for (int i = 0; i < FU_NUMBER; i++) begin
          if (push[i]) begin
            mem[i][wr_ptr[i]] <= fu_entry[i];
            wr_ptr[i]         <= wr_ptr[i] + PW'(1);
          end
          if (pop[i]) rd_ptr[i] <= rd_ptr[i] + PW'(1);
          count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
        end
        if (g1_vld)      rr_ptr <= next_fu(g1_idx);
        else if (g0_vld) rr_ptr <= next_fu(g0_idx);
      end
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(|(fu_valid & ~fu_ready)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand sequences, and a queue-based reference model.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic [3:0]  fu_valid, fu_exc_valid, fu_ready;
  logic [23:0] fu_dest;
  logic [127:0] fu_data;
  logic [11:0] fu_ticket;
  logic [15:0] fu_exc_cause;
  logic [1:0]  wb_valid, wb_exc_valid;
  logic [11:0] wb_dest;
  logic [63:0] wb_data;
  logic [5:0]  wb_ticket;
  logic [7:0]  wb_exc_cause;
  logic [3:0]  wb_src_fu;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_dest(fu_dest), .fu_data(fu_data), .fu_ticket(fu_ticket),
    .fu_exc_valid(fu_exc_valid), .fu_exc_cause(fu_exc_cause), .fu_ready(fu_ready),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .wb_ticket(wb_ticket),
    .wb_exc_valid(wb_exc_valid), .wb_exc_cause(wb_exc_cause), .wb_src_fu(wb_src_fu)
  );

  typedef struct packed {
    logic [5:0]  dest;
    logic [31:0] data;
    logic [2:0]  ticket;
    logic        exc_v;
    logic [3:0]  cause;
  } ent_t;

  typedef struct packed {
    logic [1:0]  v;
    logic [47:0] p0;
    logic [47:0] p1;
    logic [3:0]  rdy;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic       fl;
    logic [3:0] exc;
    logic [1:0] ev;
    logic [1:0] s0;
    logic [1:0] s1;
    logic [1:0] eexc;
    logic [3:0] er;
  } vec_t;

  ent_t       mf [4][4];
  int         mcnt [4];
  int         m_rr;
  exp_t       exp_q [$];
  logic [5:0] pl_dest [4];
  logic [31:0] pl_data [4];
  logic [2:0] pl_ticket [4];
  logic       pl_exc [4];
  logic [3:0] pl_cause [4];
  bit         pl_hold;
  vec_t       vt [15];
  int         errors = 0;
  int         checks = 0;
  int         first_low;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [47:0] port_word(input int p);
    return {wb_dest[p*6 +: 6], wb_data[p*32 +: 32], wb_ticket[p*3 +: 3],
            wb_exc_valid[p], wb_exc_cause[p*4 +: 4], wb_src_fu[p*2 +: 2]};
  endfunction

  task automatic mpop(input int f);
    for (int j = 0; j < 3; j++) mf[f][j] = mf[f][j+1];
    mcnt[f]--;
  endtask

  // One clock: drive inputs, predict with the model, push the prediction, compare after the edge.
  task automatic cycle(input logic [3:0] req, input logic fl, input logic [3:0] exc);
    logic [3:0] vm, mrdy;
    exp_t e, got;
    int g0, g1, idx;
    if (!pl_hold) begin
      for (int i = 0; i < 4; i++) begin
        pl_dest[i]   = 6'($urandom);
        pl_data[i]   = $urandom;
        pl_ticket[i] = 3'($urandom);
        pl_exc[i]    = exc[i];
        pl_cause[i]  = exc[i] ? 4'h2 : 4'($urandom);
      end
    end
    vm = req & fu_ready;
    fu_valid = vm;
    flush    = fl;
    for (int i = 0; i < 4; i++) begin
      fu_dest[i*6 +: 6]       = pl_dest[i];
      fu_data[i*32 +: 32]     = pl_data[i];
      fu_ticket[i*3 +: 3]     = pl_ticket[i];
      fu_exc_valid[i]         = pl_exc[i];
      fu_exc_cause[i*4 +: 4]  = pl_cause[i];
    end
    g0 = -1;
    g1 = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (m_rr + k) % 4;
      if (mcnt[idx] > 0) begin
        if (g0 < 0) g0 = idx;
        else if (g1 < 0) g1 = idx;
      end
    end
    e = '0;
    if (!fl && g0 >= 0) begin e.v[0] = 1'b1; e.p0 = {mf[g0][0], 2'(g0)}; end
    if (!fl && g1 >= 0) begin e.v[1] = 1'b1; e.p1 = {mf[g1][0], 2'(g1)}; end
    for (int i = 0; i < 4; i++) mrdy[i] = (mcnt[i] < 2);
    if (fl) begin
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
    end else begin
      if (g0 >= 0) mpop(g0);
      if (g1 >= 0) mpop(g1);
      for (int i = 0; i < 4; i++)
        if (vm[i] && mrdy[i] && mcnt[i] < 4) begin
          mf[i][mcnt[i]] = {pl_dest[i], pl_data[i], pl_ticket[i], pl_exc[i], pl_cause[i]};
          mcnt[i]++;
        end
      if (g1 >= 0) m_rr = (g1 + 1) % 4;
      else if (g0 >= 0) m_rr = (g0 + 1) % 4;
    end
    for (int i = 0; i < 4; i++) e.rdy[i] = (mcnt[i] < 2);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    fu_valid = '0;
    flush    = 1'b0;
    got = exp_q.pop_front();
    chk("wb_valid", 64'(wb_valid), 64'(got.v));
    chk("port0", 64'(port_word(0)), 64'(got.p0));
    chk("port1", 64'(port_word(1)), 64'(got.p1));
    chk("fu_ready", 64'(fu_ready), 64'(got.rdy));
  endtask

  task automatic do_reset(input logic fl);
    rst      = 1'b1;
    flush    = fl;
    fu_valid = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_fu_ready", 64'(fu_ready), 64'h0);
      chk("rst_wb_valid", 64'(wb_valid), 64'h0);
      chk("rst_port0", 64'(port_word(0)), 64'h0);
      chk("rst_port1", 64'(port_word(1)), 64'h0);
    end
    rst   = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    chk("release_fu_ready", 64'(fu_ready), 64'hF);
    chk("release_wb_valid", 64'(wb_valid), 64'h0);
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
    m_rr = 0;
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; fu_valid = '0; fu_dest = '0; fu_data = '0;
    fu_ticket = '0; fu_exc_valid = '0; fu_exc_cause = '0; pl_hold = 1'b0;
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
    m_rr = 0;
    do_reset(1'b0);

    // Single ALU result with fixed payload.
    pl_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pl_dest[i] = '0; pl_data[i] = '0; pl_ticket[i] = '0; pl_exc[i] = 1'b0; pl_cause[i] = '0;
    end
    pl_dest[2] = 6'h0A; pl_data[2] = 32'hDEADBEEF; pl_ticket[2] = 3'd3;
    cycle(4'b0100, 1'b0, 4'b0000);
    chk("single_no_bypass", 64'(wb_valid), 64'h0);
    cycle(4'b0000, 1'b0, 4'b0000);
    pl_hold = 1'b0;
    chk("single_valid", 64'(wb_valid), 64'h1);
    chk("single_dest", 64'(wb_dest[5:0]), 64'h0A);
    chk("single_data", 64'(wb_data[31:0]), 64'hDEADBEEF);
    chk("single_ticket", 64'(wb_ticket[2:0]), 64'h3);
    chk("single_src", 64'(wb_src_fu[1:0]), 64'h2);

    // req, flush, exc, expected valid, src0, src1, exc_valid, fu_ready
    vt[0]  = '{4'b1000, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 2'b00, 4'b1111};
    vt[1]  = '{4'b0000, 1'b0, 4'b0000, 2'b01, 2'd3, 2'd0, 2'b00, 4'b1111};
    vt[2]  = '{4'b1111, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 2'b00, 4'b1111};
    vt[3]  = '{4'b0000, 1'b0, 4'b0000, 2'b11, 2'd0, 2'd1, 2'b00, 4'b1111};
    vt[4]  = '{4'b0000, 1'b0, 4'b0000, 2'b11, 2'd2, 2'd3, 2'b00, 4'b1111};
    vt[5]  = '{4'b0000, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 2'b00, 4'b1111};
    vt[6]  = '{4'b1010, 1'b0, 4'b1000, 2'b00, 2'd0, 2'd0, 2'b00, 4'b1111};
    vt[7]  = '{4'b0000, 1'b0, 4'b0000, 2'b11, 2'd1, 2'd3, 2'b10, 4'b1111};
    vt[8]  = '{4'b1111, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 2'b00, 4'b1111};
    vt[9]  = '{4'b0001, 1'b0, 4'b0000, 2'b11, 2'd0, 2'd1, 2'b00, 4'b1111};
    vt[10] = '{4'b0001, 1'b0, 4'b0000, 2'b11, 2'd2, 2'd3, 2'b00, 4'b1110};
    vt[11] = '{4'b0010, 1'b1, 4'b0000, 2'b00, 2'd0, 2'd0, 2'b00, 4'b1111};
    vt[12] = '{4'b0000, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 2'b00, 4'b1111};
    vt[13] = '{4'b0011, 1'b0, 4'b0000, 2'b00, 2'd0, 2'd0, 2'b00, 4'b1111};
    vt[14] = '{4'b0000, 1'b0, 4'b0000, 2'b11, 2'd0, 2'd1, 2'b00, 4'b1111};
    for (int i = 0; i < 15; i++) begin
      cycle(vt[i].req, vt[i].fl, vt[i].exc);
      chk($sformatf("vec%0d_valid", i), 64'(wb_valid), 64'(vt[i].ev));
      if (vt[i].ev[0]) chk($sformatf("vec%0d_src0", i), 64'(wb_src_fu[1:0]), 64'(vt[i].s0));
      if (vt[i].ev[1]) chk($sformatf("vec%0d_src1", i), 64'(wb_src_fu[3:2]), 64'(vt[i].s1));
      chk($sformatf("vec%0d_exc", i), 64'(wb_exc_valid), 64'(vt[i].eexc));
      chk($sformatf("vec%0d_ready", i), 64'(fu_ready), 64'(vt[i].er));
    end

    // All four FUs push every cycle; ALU must see back-pressure quickly.
    first_low = -1;
    for (int c = 0; c < 20; c++) begin
      cycle(4'b1111, 1'b0, 4'($urandom));
      if (first_low < 0 && !fu_ready[2]) first_low = c;
    end
    chk("alu_backpressure", 64'(first_low >= 0 && first_low <= 3), 64'h1);

    for (int c = 0; c < 150; c++)
      cycle(4'($urandom), ($urandom_range(0, 19) == 0), 4'($urandom));

    // Reset asserted together with flush: rr_ptr returns to 0.
    do_reset(1'b1);
    cycle(4'b1111, 1'b0, 4'b0000);
    cycle(4'b0000, 1'b0, 4'b0000);
    chk("rst_flush_valid", 64'(wb_valid), 64'h3);
    chk("rst_flush_src", 64'(wb_src_fu), 64'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
